// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Read-owner encoding and the default starvation limit.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Debug-port starvation counter and force compare.
// Only present in builds with DMEM_ARB_FAIRNESS_EN defined.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic gnt_dbg,
    output logic force_dbg
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SAT = CW'(STARVE_MAX);

    logic [CW-1:0] starve;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve <= '0;
        end else if (gnt_dbg || !dbg_req) begin
            starve <= '0;
        end else if (cpu_req && (starve != SAT)) begin
            starve <= starve + 1'b1;
        end
    end

    assign force_dbg = (starve == SAT) && dbg_req;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the M stage and the debug port.
// DMEM_ARB_FAIRNESS_EN adds a forced debug grant after STARVE_MAX losses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic   force_dbg;
    logic   gnt_cpu;
    logic   gnt_dbg;
    owner_e rd_own;
    owner_e rd_own_nxt;

`ifdef DMEM_ARB_FAIRNESS_EN
    dmem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .dbg_req  (dbg_req),
        .gnt_dbg  (gnt_dbg),
        .force_dbg(force_dbg)
    );
`else
    assign force_dbg = 1'b0;
`endif

    always_comb begin
        gnt_cpu    = cpu_req && !force_dbg;
        gnt_dbg    = dbg_req && (!cpu_req || force_dbg);
        ram_en     = gnt_cpu || gnt_dbg;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        rd_own_nxt = OWN_NONE;
        unique case (1'b1)
            gnt_cpu: begin
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                if (!cpu_we) rd_own_nxt = OWN_CPU;
            end
            gnt_dbg: begin
                ram_we    = dbg_we;
                ram_addr  = dbg_addr;
                ram_wdata = dbg_wdata;
                if (!dbg_we) rd_own_nxt = OWN_DBG;
            end
            default: ;
        endcase
    end

    // Tracks which port the RAM's next-cycle read data belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_own <= OWN_NONE;
        end else begin
            rd_own <= rd_own_nxt;
        end
    end

    assign cpu_stall  = cpu_req && !gnt_cpu;
    assign dbg_gnt    = gnt_dbg;
    assign cpu_rdata  = ram_rdata;
    assign dbg_rdata  = ram_rdata;
    assign dbg_rvalid = (rd_own == OWN_DBG);

endmodule
